rtl_kernel_mc_ctrl: RTL and testbench

//  N-channel kernel control sequencer for the vadd-style RTL kernel.
//  - Turns the host ap_ctrl handshake into per-channel start pulses.
//  - Collects per-channel done pulses into one host done, for any channel count.
//  - Modes: ap_ctrl_hs or ap_ctrl_chain. Other features:
//    - runtime transfer size and constant, taken from scalars;
//    - channel enable mask;
//    - watchdog timeout;
//    - run-cycle counter.

---
 rtl/rtl_kernel_mc_ctrl.sv | 133 +++++++++++++
 tb/tb_rtl_kernel_mc_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rtl_kernel_mc_ctrl.sv
// Control sequencer for an N-channel vadd-style kernel.
// Turns the host ap_ctrl handshake into per-channel start pulses and merges the channel done pulses.
module rtl_kernel_mc_ctrl #(
  parameter int unsigned C_NUM_CHANNELS      = 4,
  parameter int unsigned C_XFER_SIZE_WIDTH   = 32,
  parameter int unsigned C_DEFAULT_LEN_BYTES = 16384,
  parameter int unsigned C_BEAT_BYTES        = 64,
  parameter int unsigned C_AP_CTRL_CHAIN     = 0,
  parameter int unsigned C_CNT_WIDTH         = 32
) (
  input  logic                         ap_clk,
  input  logic                         areset,
  input  logic                         ap_start,
  input  logic                         ap_continue,
  output logic                         ap_idle,
  output logic                         ap_done,
  output logic                         ap_ready,
  input  logic [31:0]                  scalar00,
  input  logic [31:0]                  scalar01,
  input  logic [C_NUM_CHANNELS-1:0]    chan_mask,
  input  logic [C_CNT_WIDTH-1:0]       timeout_cycles,
  output logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_size_in_bytes,
  output logic [31:0]                  ctrl_constant,
  output logic [C_NUM_CHANNELS-1:0]    chan_start,
  input  logic [C_NUM_CHANNELS-1:0]    chan_done,
  output logic                         status_timeout,
  output logic [C_CNT_WIDTH-1:0]       cycle_count
);

  localparam int unsigned N  = C_NUM_CHANNELS;
  localparam int unsigned CW = C_CNT_WIDTH;
  localparam int unsigned XW = C_XFER_SIZE_WIDTH;
  localparam logic [31:0] BeatMask = ~(32'(C_BEAT_BYTES) - 32'd1);

  typedef enum logic [1:0] {StIdle, StStart, StRun, StDone} state_e;

  state_e         state_q, state_d;
  logic           ap_start_q;
  logic           start_pulse;
  logic [N-1:0]   mask_eff_q;
  logic [N-1:0]   done_acc_q;
  logic [N-1:0]   done_acc_next;
  logic           all_done;
  logic           tmo_hit;
  logic [CW-1:0]  run_cnt_q;
  logic [CW-1:0]  cnt_inc;
  logic           ready_q;
  logic           timeout_q;
  logic [CW-1:0]  cycle_count_q;
  logic [XW-1:0]  size_q;
  logic [31:0]    const_q;
  logic [31:0]    size_round;
  logic [31:0]    size_sel;

  always_comb begin
    start_pulse   = ap_start & ~ap_start_q;
    done_acc_next = done_acc_q | (chan_done & mask_eff_q);
    all_done      = &(done_acc_next | ~mask_eff_q);
    cnt_inc       = (&run_cnt_q) ? run_cnt_q : run_cnt_q + CW'(1);
    tmo_hit       = (timeout_cycles != '0) && (run_cnt_q == timeout_cycles - CW'(1)) && !all_done;
    size_round    = scalar00 & BeatMask;
    if (scalar00 == 32'd0) begin
      size_sel = 32'(C_DEFAULT_LEN_BYTES);
    end else if (size_round == 32'd0) begin
      size_sel = 32'(C_BEAT_BYTES);
    end else begin
      size_sel = size_round;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:         if (start_pulse) state_d = StStart;
      StStart, StRun: state_d = (all_done || tmo_hit) ? StDone : StRun;
      // hs mode always leaves after one cycle; chain mode waits for ap_continue
      StDone:         if ((C_AP_CTRL_CHAIN == 0) || ap_continue) state_d = StIdle;
      default:        state_d = StIdle;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state_q       <= StIdle;
      ap_start_q    <= 1'b0;
      mask_eff_q    <= '0;
      done_acc_q    <= '0;
      run_cnt_q     <= '0;
      ready_q       <= 1'b0;
      timeout_q     <= 1'b0;
      cycle_count_q <= '0;
      size_q        <= XW'(C_DEFAULT_LEN_BYTES);
      const_q       <= 32'd1;
    end else begin
      state_q    <= state_d;
      ap_start_q <= ap_start;
      ready_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_pulse) begin
            mask_eff_q <= (chan_mask == '0) ? '1 : chan_mask;
            size_q     <= XW'(size_sel);
            const_q    <= scalar01;
            done_acc_q <= '0;
            timeout_q  <= 1'b0;
            run_cnt_q  <= '0;
          end
        end
        StStart, StRun: begin
          done_acc_q <= done_acc_next;
          run_cnt_q  <= cnt_inc;
          if (state_d == StDone) begin
            cycle_count_q <= cnt_inc;
            ready_q       <= 1'b1;
            // leaving without all_done can only mean the watchdog fired
            if (!all_done) timeout_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ap_idle                 = (state_q == StIdle);
  assign ap_done                 = (state_q == StDone);
  assign ap_ready                = ready_q;
  assign chan_start              = (state_q == StStart) ? mask_eff_q : '0;
  assign ctrl_xfer_size_in_bytes = size_q;
  assign ctrl_constant           = const_q;
  assign status_timeout          = timeout_q;
  assign cycle_count             = cycle_count_q;

endmodule

// File: tb/tb_rtl_kernel_mc_ctrl.sv
// Bench for rtl_kernel_mc_ctrl: table vectors, randomized runs against an offset model,
// and hand sequences for chain handshake and mid-run reset.
module tb_rtl_kernel_mc_ctrl;

  typedef struct packed {
    logic [3:0]       mask;
    logic [31:0]      s0;
    logic [31:0]      s1;
    logic [31:0]      tmo;
    logic [3:0][11:0] d;       // done offset per channel, counted from the START cycle
    logic [31:0]      e_size;
    logic [3:0]       e_start;
    logic [11:0]      e_off;   // offset of the DONE cycle, also the expected cycle_count
    logic             e_to;
  } vec_t;

  logic        ap_clk = 1'b0;
  logic        areset = 1'b1;
  logic        ap_start = 1'b0;
  logic        ap_start_c = 1'b0;
  logic        ap_continue = 1'b1;
  logic [31:0] scalar00 = '0;
  logic [31:0] scalar01 = '0;
  logic [3:0]  chan_mask = '0;
  logic [31:0] timeout_cycles = '0;
  logic [3:0]  chan_done = '0;

  logic        ap_idle, ap_done, ap_ready, status_timeout;
  logic [31:0] size, ctrl_constant, cycle_count;
  logic [3:0]  chan_start;
  logic        c_ap_idle, c_ap_done, c_ap_ready, c_status_timeout;
  logic [31:0] c_size, c_constant, c_cycle_count;
  logic [3:0]  c_chan_start;

  int errors = 0;
  int checks = 0;

  always #5 ap_clk = ~ap_clk;

  rtl_kernel_mc_ctrl #(.C_AP_CTRL_CHAIN(0)) u_hs (
    .ap_clk(ap_clk), .areset(areset), .ap_start(ap_start), .ap_continue(ap_continue),
    .ap_idle(ap_idle), .ap_done(ap_done), .ap_ready(ap_ready),
    .scalar00(scalar00), .scalar01(scalar01), .chan_mask(chan_mask),
    .timeout_cycles(timeout_cycles), .ctrl_xfer_size_in_bytes(size),
    .ctrl_constant(ctrl_constant), .chan_start(chan_start), .chan_done(chan_done),
    .status_timeout(status_timeout), .cycle_count(cycle_count)
  );

  rtl_kernel_mc_ctrl #(.C_AP_CTRL_CHAIN(1)) u_chain (
    .ap_clk(ap_clk), .areset(areset), .ap_start(ap_start_c), .ap_continue(ap_continue),
    .ap_idle(c_ap_idle), .ap_done(c_ap_done), .ap_ready(c_ap_ready),
    .scalar00(scalar00), .scalar01(scalar01), .chan_mask(chan_mask),
    .timeout_cycles(timeout_cycles), .ctrl_xfer_size_in_bytes(c_size),
    .ctrl_constant(c_constant), .chan_start(c_chan_start), .chan_done(chan_done),
    .status_timeout(c_status_timeout), .cycle_count(c_cycle_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " idle"}, ap_idle, 1);
    chk({tag, " done"}, ap_done, 0);
    chk({tag, " ready"}, ap_ready, 0);
    chk({tag, " chan_start"}, chan_start, 0);
    chk({tag, " status_timeout"}, status_timeout, 0);
    chk({tag, " cycle_count"}, cycle_count, 0);
    chk({tag, " size"}, size, 16384);
    chk({tag, " constant"}, ctrl_constant, 1);
  endtask

  function automatic vec_t mk(input logic [3:0] mask, input logic [31:0] s0, input logic [31:0] s1,
                              input logic [31:0] tmo, input int d0, input int d1, input int d2,
                              input int d3);
    vec_t v;
    v = '0;
    v.mask = mask; v.s0 = s0; v.s1 = s1; v.tmo = tmo;
    v.d[0] = 12'(d0); v.d[1] = 12'(d1); v.d[2] = 12'(d2); v.d[3] = 12'(d3);
    return v;
  endfunction

  // Whole-run outcome from the rules: the run ends one cycle after the last enabled done,
  // or at the watchdog limit if that limit is reached first.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int last;
    logic [3:0] me;
    r = v;
    last = -1;
    me = (v.mask == 4'd0) ? 4'hF : v.mask;
    r.e_start = me;
    if (v.s0 == 0) r.e_size = 16384;
    else begin
      r.e_size = (v.s0 / 64) * 64;
      if (r.e_size == 0) r.e_size = 64;
    end
    for (int i = 0; i < 4; i++) if (me[i] && int'(v.d[i]) > last) last = int'(v.d[i]);
    if (v.tmo != 0 && last >= int'(v.tmo)) begin
      r.e_off = 12'(v.tmo); r.e_to = 1'b1;
    end else begin
      r.e_off = 12'(last + 1); r.e_to = 1'b0;
    end
    return r;
  endfunction

  task automatic run_txn(input string tag, input vec_t v);
    chan_mask = v.mask; scalar00 = v.s0; scalar01 = v.s1; timeout_cycles = v.tmo;
    chan_done = '0; ap_start = 1'b1;
    for (int k = 0; k <= int'(v.e_off); k++) begin
      @(negedge ap_clk);
      if (k == 0) begin
        chk({tag, " chan_start"}, chan_start, v.e_start);
        chk({tag, " size"}, size, v.e_size);
        chk({tag, " constant"}, ctrl_constant, v.s1);
        chk({tag, " busy"}, ap_idle, 0);
        chk({tag, " timeout cleared"}, status_timeout, 0);
      end
      if (k == 1 && v.e_off > 1) chk({tag, " start pulse width"}, chan_start, 0);
      chk({tag, " ap_done"}, ap_done, (k == int'(v.e_off)));
      if (k == int'(v.e_off)) begin
        chk({tag, " ap_ready"}, ap_ready, 1);
        chk({tag, " cycle_count"}, cycle_count, v.e_off);
        chk({tag, " status_timeout"}, status_timeout, v.e_to);
      end
      for (int i = 0; i < 4; i++) chan_done[i] = (k != int'(v.e_off)) && (int'(v.d[i]) == k);
    end
    @(negedge ap_clk);
    chan_done = '0;
    chk({tag, " idle after done"}, ap_idle, 1);
    chk({tag, " done width"}, ap_done, 0);
    @(negedge ap_clk);
    chk({tag, " no restart idle"}, ap_idle, 1);
    chk({tag, " no restart start"}, chan_start, 0);
    ap_start = 1'b0;
    @(negedge ap_clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tab[7];
    vec_t v;
    int hi;

    tab[0] = mk(4'b0000, 0, 5, 0, 10, 20, 20, 35);
    tab[0].e_size = 16384; tab[0].e_start = 4'hF; tab[0].e_off = 36; tab[0].e_to = 0;
    tab[1] = mk(4'b0101, 1000, 7, 0, 5, 3, 12, 3);
    tab[1].e_size = 960; tab[1].e_start = 4'b0101; tab[1].e_off = 13; tab[1].e_to = 0;
    tab[2] = mk(4'b0000, 0, 9, 50, 4, 6, 1000, 8);
    tab[2].e_size = 16384; tab[2].e_start = 4'hF; tab[2].e_off = 50; tab[2].e_to = 1;
    tab[3] = mk(4'b1111, 10, 3, 0, 0, 0, 0, 0);
    tab[3].e_size = 64; tab[3].e_start = 4'hF; tab[3].e_off = 1; tab[3].e_to = 0;
    tab[4] = mk(4'b0010, 64, 11, 20, 2, 19, 2, 2);
    tab[4].e_size = 64; tab[4].e_start = 4'b0010; tab[4].e_off = 20; tab[4].e_to = 0;
    tab[5] = mk(4'b0001, 130, 12, 20, 20, 1, 1, 1);
    tab[5].e_size = 128; tab[5].e_start = 4'b0001; tab[5].e_off = 20; tab[5].e_to = 1;
    tab[6] = mk(4'b1000, 32'hFFFF_FFFF, 13, 0, 1, 1, 1, 2);
    tab[6].e_size = 32'hFFFF_FFC0; tab[6].e_start = 4'b1000; tab[6].e_off = 3; tab[6].e_to = 0;

    repeat (3) @(negedge ap_clk);
    areset = 1'b0;
    @(negedge ap_clk);
    chk_reset("reset");

    for (int i = 0; i < 7; i++) run_txn($sformatf("vec%0d", i), tab[i]);

    for (int n = 0; n < 25; n++) begin
      int sel;
      v = '0;
      v.mask = 4'($urandom_range(0, 15));
      sel = int'($urandom_range(0, 3));
      if (sel == 0) v.s0 = 0;
      else if (sel == 1) v.s0 = $urandom_range(1, 63);
      else if (sel == 2) v.s0 = $urandom_range(64, 100000);
      else v.s0 = $urandom;
      v.s1 = $urandom;
      v.tmo = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 45);
      for (int i = 0; i < 4; i++) v.d[i] = 12'($urandom_range(0, 40));
      run_txn($sformatf("rnd%0d", n), model(v));
    end

    // chain mode: ap_done held until ap_continue, second start in DONE ignored
    chan_mask = '0; timeout_cycles = '0; scalar00 = 0; ap_continue = 1'b0; ap_start_c = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge ap_clk);
      if (k == 0) chk("chain chan_start", c_chan_start, 4'hF);
      chan_done = (k == 2) ? 4'hF : 4'h0;
    end
    @(negedge ap_clk);
    chan_done = '0;
    chk("chain done entry", c_ap_done, 1);
    chk("chain ready entry", c_ap_ready, 1);
    ap_start_c = 1'b0;
    hi = 1;
    for (int j = 1; j < 8; j++) begin
      @(negedge ap_clk);
      if (c_ap_done) hi++;
      if (j == 1) chk("chain ready pulse", c_ap_ready, 0);
      if (j == 2) ap_start_c = 1'b1;
      if (j == 7) ap_continue = 1'b1;
    end
    @(negedge ap_clk);
    chk("chain done cycles", 64'(hi), 8);
    chk("chain done cleared", c_ap_done, 0);
    chk("chain idle", c_ap_idle, 1);
    @(negedge ap_clk);
    chk("chain restart ignored idle", c_ap_idle, 1);
    chk("chain restart ignored start", c_chan_start, 0);
    ap_start_c = 1'b0;
    @(negedge ap_clk);

    // chain mode with ap_continue already high: one-cycle ap_done
    ap_start_c = 1'b1;
    @(negedge ap_clk);
    chan_done = 4'hF;
    @(negedge ap_clk);
    chan_done = '0;
    chk("chain cont done", c_ap_done, 1);
    @(negedge ap_clk);
    chk("chain cont done width", c_ap_done, 0);
    chk("chain cont idle", c_ap_idle, 1);
    ap_start_c = 1'b0;
    @(negedge ap_clk);

    // mid-run reset: stale done on channel 0 must not count afterwards
    chan_mask = '0; scalar00 = 0; timeout_cycles = '0; ap_start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge ap_clk);
      chan_done = (k == 2) ? 4'b0001 : 4'b0000;
      if (k == 5) begin
        chk("t5 running", ap_idle, 0);
        chan_done = 4'hF; areset = 1'b1; ap_start = 1'b0;
      end
    end
    @(negedge ap_clk);
    areset = 1'b0; chan_done = '0;
    chk_reset("t5 reset");
    @(negedge ap_clk);
    v = mk(4'b0000, 0, 21, 0, 6, 4, 4, 4);
    v.e_size = 16384; v.e_start = 4'hF; v.e_off = 7; v.e_to = 0;
    run_txn("t5 fresh", v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
